// File: rtl/bpb_update_queue.sv
// bpb_update_queue
//   Circular queue between the dual-issue branch resolution side and the
//   single-write branch prediction buffer training port. It accepts up to two
//   resolved branches per cycle and drains one per cycle into the BPB. Draining
//   pauses while the BPB is stalled.
//
// Ports
//   clk            clock, all state updates on posedge
//   reset          asynchronous active-low reset
//   stall          BPB stalled; the head is held this cycle
//   in_valid[1:0]  per-slot resolved strobe, slot 0 older
//   in_pc          {slot1 pc, slot0 pc}
//   in_taken[1:0]  per-slot resolved direction
//   in_ready       at least two free entries
//   wen            head valid (BPB update request)
//   pc_commit      head PC
//   taken_commit   head direction
//   count          occupancy
//   drop_err       sticky, set when a cycle's push was discarded
//   stat_push      accepted-push counter (BPB_UPDQ_STATS_EN)
//   stat_taken     accepted-taken counter (BPB_UPDQ_STATS_EN)
//
// Optional feature macro: BPB_UPDQ_STATS_EN. When it is undefined, both stat
// outputs are tied to 0.
module bpb_update_queue #(
  parameter int DEPTH    = 8,
  parameter int PC_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic [1:0]                in_valid,
  input  logic [2*PC_WIDTH-1:0]     in_pc,
  input  logic [1:0]                in_taken,
  output logic                      in_ready,
  output logic                      wen,
  output logic [PC_WIDTH-1:0]       pc_commit,
  output logic                      taken_commit,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      drop_err,
  output logic [15:0]               stat_push,
  output logic [15:0]               stat_taken
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_WIDTH-1:0] pc_mem [DEPTH];
  logic [DEPTH-1:0]    tk_mem;

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          drop_q, drop_d;

  logic          pop;
  logic [1:0]    n_push;
  logic [AW-1:0] wptr_s1;

  // in_ready is conservative: one free slot is not enough, because the
  // producer may present two entries without looking at in_valid.
  assign in_ready     = (count_q <= CW'(DEPTH - 2));
  assign wen          = (count_q != '0);
  assign pop          = wen & ~stall;
  assign n_push       = in_ready ? ({1'b0, in_valid[0]} + {1'b0, in_valid[1]}) : 2'd0;
  // Slot 1 follows slot 0 only when slot 0 is present; otherwise it takes the tail.
  assign wptr_s1      = wptr_q + AW'(in_valid[0]);

  assign pc_commit    = pc_mem[rptr_q];
  assign taken_commit = tk_mem[rptr_q];
  assign count        = count_q;
  assign drop_err     = drop_q;

  always_comb begin
    wptr_d  = wptr_q + AW'(n_push);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + CW'(n_push) - CW'(pop);
    drop_d  = drop_q | (~in_ready & (|in_valid));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  // Entry storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (in_ready) begin
      if (in_valid[0]) begin
        pc_mem[wptr_q] <= in_pc[PC_WIDTH-1:0];
        tk_mem[wptr_q] <= in_taken[0];
      end
      if (in_valid[1]) begin
        pc_mem[wptr_s1] <= in_pc[2*PC_WIDTH-1:PC_WIDTH];
        tk_mem[wptr_s1] <= in_taken[1];
      end
    end
  end

`ifdef BPB_UPDQ_STATS_EN
  logic [15:0] stat_push_q, stat_taken_q;
  logic [1:0]  n_taken;

  assign n_taken = in_ready ? ({1'b0, in_valid[0] & in_taken[0]} +
                               {1'b0, in_valid[1] & in_taken[1]}) : 2'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_push_q  <= '0;
      stat_taken_q <= '0;
    end else begin
      stat_push_q  <= stat_push_q + 16'(n_push);
      stat_taken_q <= stat_taken_q + 16'(n_taken);
    end
  end

  assign stat_push  = stat_push_q;
  assign stat_taken = stat_taken_q;
`else
  assign stat_push  = '0;
  assign stat_taken = '0;
`endif

endmodule

// File: tb/tb_bpb_update_queue.sv
module tb_bpb_update_queue;
  localparam int DEPTH = 8;
  localparam int PW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk, reset, stall;
  logic [1:0]    in_valid, in_taken;
  logic [2*PW-1:0] in_pc;
  logic          in_ready, wen, taken_commit, drop_err;
  logic [PW-1:0] pc_commit;
  logic [CW-1:0] count;
  logic [15:0]   stat_push, stat_taken;

  bpb_update_queue #(.DEPTH(DEPTH), .PC_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .in_valid(in_valid), .in_pc(in_pc),
    .in_taken(in_taken), .in_ready(in_ready), .wen(wen), .pc_commit(pc_commit),
    .taken_commit(taken_commit), .count(count), .drop_err(drop_err),
    .stat_push(stat_push), .stat_taken(stat_taken));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the queue contents as an ordered list of outcomes.
  typedef struct { logic [PW-1:0] pc; logic tk; } ent_t;
  ent_t        mq[$];
  bit          m_drop;
  logic [15:0] m_sp, m_st;

  typedef struct {
    logic        s;
    logic [1:0]  v;
    logic [31:0] pc0, pc1;
    logic [1:0]  tk;
    logic        e_wen;
    int          e_cnt;
    logic        e_rdy;
    logic [31:0] e_pc;
    logic        e_tk;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".wen"}, 64'(wen), 64'(mq.size() != 0));
    chk({tag, ".count"}, 64'(count), 64'(mq.size()));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'((DEPTH - mq.size()) >= 2));
    chk({tag, ".drop_err"}, 64'(drop_err), 64'(m_drop));
    if (mq.size() != 0) begin
      chk({tag, ".pc_commit"}, 64'(pc_commit), 64'(mq[0].pc));
      chk({tag, ".taken_commit"}, 64'(taken_commit), 64'(mq[0].tk));
    end
`ifdef BPB_UPDQ_STATS_EN
    chk({tag, ".stat_push"}, 64'(stat_push), 64'(m_sp));
    chk({tag, ".stat_taken"}, 64'(stat_taken), 64'(m_st));
`else
    chk({tag, ".stat_push"}, 64'(stat_push), 64'd0);
    chk({tag, ".stat_taken"}, 64'(stat_taken), 64'd0);
`endif
  endtask

  // One clock: drive at negedge, advance the model, check just after posedge.
  task automatic step(input string tag, input logic s, input logic [1:0] v,
                      input logic [31:0] p0, input logic [31:0] p1, input logic [1:0] t);
    bit rdy;
    @(negedge clk);
    stall = s; in_valid = v; in_pc = {p1, p0}; in_taken = t;
    rdy = (DEPTH - mq.size()) >= 2;
    if (mq.size() != 0 && !s) void'(mq.pop_front());
    if (rdy) begin
      if (v[0]) begin mq.push_back('{pc: p0, tk: t[0]}); m_sp++; if (t[0]) m_st++; end
      if (v[1]) begin mq.push_back('{pc: p1, tk: t[1]}); m_sp++; if (t[1]) m_st++; end
    end else if (v != 2'b00) begin
      m_drop = 1'b1;
    end
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset(input string tag);
    in_valid = 2'b00;
    #1 reset = 1'b0;
    #1;
    chk({tag, ".rst_count"}, 64'(count), 64'd0);
    chk({tag, ".rst_wen"}, 64'(wen), 64'd0);
    chk({tag, ".rst_ready"}, 64'(in_ready), 64'd1);
    chk({tag, ".rst_drop"}, 64'(drop_err), 64'd0);
    chk({tag, ".rst_stat"}, 64'({stat_push, stat_taken}), 64'd0);
    mq.delete(); m_drop = 0; m_sp = 0; m_st = 0;
    #1 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; in_valid = 2'b00; in_pc = '0; in_taken = 2'b00;
    m_drop = 0; m_sp = 0; m_st = 0;

    tbl[0] = '{1'b0, 2'b11, 32'h1000_0020, 32'h1000_0040, 2'b10, 1'b1, 2, 1'b1, 32'h1000_0020, 1'b0};
    tbl[1] = '{1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1, 1'b1, 32'h1000_0040, 1'b1};
    tbl[2] = '{1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 0, 1'b1, 32'h0, 1'b0};
    tbl[3] = '{1'b0, 2'b10, 32'hDEAD_0000, 32'hBFC0_0100, 2'b01, 1'b1, 1, 1'b1, 32'hBFC0_0100, 1'b0};
    tbl[4] = '{1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1, 1'b1, 32'hBFC0_0100, 1'b0};
    tbl[5] = '{1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 0, 1'b1, 32'h0, 1'b0};

    // Reset, then idle.
    repeat (2) @(posedge clk);
    #1;
    chk("reset.wen", 64'(wen), 64'd0);
    chk("reset.count", 64'(count), 64'd0);
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    chk("reset.drop_err", 64'(drop_err), 64'd0);
    @(negedge clk) reset = 1'b1;
    step("idle", 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);

    // Directed vectors.
    for (int i = 0; i < 6; i++) begin
      step("tbl", tbl[i].s, tbl[i].v, tbl[i].pc0, tbl[i].pc1, tbl[i].tk);
      chk($sformatf("tbl%0d.wen", i), 64'(wen), 64'(tbl[i].e_wen));
      chk($sformatf("tbl%0d.count", i), 64'(count), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d.in_ready", i), 64'(in_ready), 64'(tbl[i].e_rdy));
      if (tbl[i].e_wen) begin
        chk($sformatf("tbl%0d.pc", i), 64'(pc_commit), 64'(tbl[i].e_pc));
        chk($sformatf("tbl%0d.tk", i), 64'(taken_commit), 64'(tbl[i].e_tk));
      end
    end

    // Fill under stall, then an overflow push that must be discarded.
    for (int i = 0; i < 4; i++)
      step("fill", 1'b1, 2'b11, 32'h2000_0000 + 32'(8*i), 32'h2000_0004 + 32'(8*i), 2'(i));
    chk("fill.count8", 64'(count), 64'd8);
    chk("fill.ready0", 64'(in_ready), 64'd0);
    step("ovf", 1'b1, 2'b01, 32'hEEEE_EEEE, 32'hEEEE_EEEF, 2'b11);
    chk("ovf.drop_err", 64'(drop_err), 64'd1);
    chk("ovf.count", 64'(count), 64'd8);
    chk("ovf.head", 64'(pc_commit), 64'h2000_0000);
    for (int i = 0; i < 8; i++) step("drain", 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);

    // Reset asserted mid-drain with five entries.
    for (int i = 0; i < 3; i++) step("pre5", 1'b1, 2'b11, $urandom, $urandom, 2'($urandom));
    step("pre5", 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    chk("middrain.count5", 64'(count), 64'd5);
    do_reset("middrain");

    // Seven entries, then alternate pop / push-2 so the tail wraps 7 -> 0.
    for (int i = 0; i < 3; i++) step("pre7", 1'b1, 2'b11, $urandom, $urandom, 2'($urandom));
    step("pre7", 1'b1, 2'b01, $urandom, 32'h0, 2'($urandom));
    chk("pre7.count", 64'(count), 64'd7);
    chk("pre7.ready0", 64'(in_ready), 64'd0);
    for (int i = 0; i < 6; i++) begin
      step("wrap.pop", 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
      step("wrap.push", 1'b0, 2'b11, 32'h3000_0000 + 32'(8*i), 32'h3000_0004 + 32'(8*i), 2'($urandom));
    end
    for (int i = 0; i < 8; i++) step("wrap.drain", 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    do_reset("wrapdone");

    // Statistics: ten accepted pushes, six taken, one discarded cycle.
    step("stat", 1'b1, 2'b11, $urandom, $urandom, 2'b11);
    step("stat", 1'b1, 2'b11, $urandom, $urandom, 2'b10);
    step("stat", 1'b1, 2'b11, $urandom, $urandom, 2'b01);
    step("stat", 1'b1, 2'b11, $urandom, $urandom, 2'b00);
    step("stat", 1'b1, 2'b11, $urandom, $urandom, 2'b11);
    step("stat", 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    step("stat", 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    step("stat", 1'b0, 2'b11, $urandom, $urandom, 2'b11);
`ifdef BPB_UPDQ_STATS_EN
    chk("stat.push10", 64'(stat_push), 64'd10);
    chk("stat.taken6", 64'(stat_taken), 64'd6);
`else
    chk("stat.push0", 64'(stat_push), 64'd0);
    chk("stat.taken0", 64'(stat_taken), 64'd0);
`endif
    do_reset("statdone");

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++)
      step("rand", ($urandom_range(0, 3) == 0), 2'($urandom), $urandom, $urandom, 2'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bpb_update_queue.md
Name: bpb_update_queue

Overview:
- Buffers resolved-branch outcomes from the dual-issue execute/commit side and drains them, one per cycle, into the branch prediction buffer's training port (wen / pc_commit / taken_commit).
- Sits directly upstream of the BPB update interface.
- Decouples two-per-cycle branch resolution from the single-write BPB, and holds updates while the BPB is stalled.

Parameters:
- DEPTH, 8, number of queue entries; power of two, minimum 4.
- PC_WIDTH, 32, width of the branch PC stored per entry.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  BPB stalled this cycle; head is not popped.
- in_valid  in  2  per-slot branch-resolved strobe; slot 0 is older.
- in_pc  in  2×PC_WIDTH  branch PC per slot.
- in_taken  in  2  resolved direction per slot.
- in_ready  out  1  at least 2 free entries; producer may assert in_valid.
- wen  out  1  head entry valid; BPB update request.
- pc_commit  out  PC_WIDTH  head entry PC.
- taken_commit  out  1  head entry direction.
- count  out  $clog2(DEPTH)+1  current occupancy.
- drop_err  out  1  sticky: a push was discarded.
- stat_push  out  16  pushed-entry counter (optional feature).
- stat_taken  out  16  pushed-taken counter (optional feature).

Behaviour:
- Storage: circular buffer of DEPTH entries {pc, taken}.
  - Read/write pointers are $clog2(DEPTH) bits with natural wrap.
  - count is held as a separate register.
- Reset (asynchronous, reset=0), takes effect immediately, including mid-operation:
  - pointers=0, count=0, drop_err=0, stat counters=0.
  - wen=0, in_ready=1. pc_commit/taken_commit reflect the head entry and are don't-care while wen=0.
  - Entry storage is not cleared.
- Push:
  - On a rising edge with in_ready=1, each valid slot is written in order: slot 0 first, then slot 1.
  - in_valid=2'b10 writes only slot 1, at the tail.
  - Number of pushes = popcount(in_valid), 0..2.
- in_ready = (DEPTH − count) ≥ 2, combinational from count. It is deliberately conservative: it drops to 0 when exactly one entry is free.
- Push with in_ready=0: the entire cycle's input is discarded, even if one slot would fit. drop_err sets and stays set until reset.
- Pop:
  - wen = (count ≠ 0), combinational from registered state.
  - pc_commit/taken_commit = entry at the read pointer.
  - Head is consumed on an edge where wen=1 and stall=0.
  - With stall=1, head and outputs stay unchanged.
- Latency: an entry pushed at edge N is visible on wen/pc_commit at the earliest in the cycle after edge N. There is no same-cycle bypass when empty.
- Simultaneous push and pop: count_next = count + pushes − pop. The pop uses the pre-edge head.
  - Full (count=DEPTH) plus pop: in_ready is 0 that cycle, so no push.
- Ordering is strict FIFO; no coalescing of identical PCs. The BPB 2-bit counter must see every outcome.
- Pointer wrap: write pointer advancing from DEPTH−1 wraps to 0; a two-entry push straddling the wrap writes index DEPTH−1, then index 0.

Optional Feature:
- Macro: BPB_UPDQ_STATS_EN.
- Defined:
  - stat_push increments by the number of accepted pushes (0..2) per edge.
  - stat_taken increments by the number of accepted pushes with in_taken=1.
  - Both wrap at 2^16, reset to 0, and do not count discarded pushes.
- Undefined: stat_push and stat_taken are constant 0 and the counter logic is not synthesized. Ports remain present.

Test Plan:
- Reset then idle → wen=0, count=0, in_ready=1, drop_err=0. Assert reset mid-drain with count=5 → count=0 and wen=0 immediately, without a clock edge.
- One cycle of in_valid=2'b11, pc={0x1000_0040 slot1, 0x1000_0020 slot0}, taken={1,0}, stall=0 → next cycle wen=1, pc_commit=0x1000_0020, taken_commit=0; following cycle pc_commit=0x1000_0040, taken_commit=1; then wen=0.
- in_valid=2'b10, pc[1]=0xBFC0_0100 → exactly one entry; count=1; pc_commit=0xBFC0_0100.
- Hold stall=1 while pushing 2 per cycle for 4 cycles (DEPTH=8) → count=8, in_ready=0 once count reaches 7. A fifth push is discarded, drop_err=1, and queue contents are unchanged.
- Pre-fill 7 entries, then alternate push-2/pop so the write pointer crosses 7→0 → drained sequence matches push order exactly; count never exceeds 8.
- With BPB_UPDQ_STATS_EN, push 10 entries of which 6 are taken, plus one discarded cycle → stat_push=10, stat_taken=6. Without the macro, both read 0.
